dmx_slot_loader: RTL and testbench



---
 rtl/dmx_pkg.sv | 17 +
 rtl/dmx_slot_ram.sv | 28 ++
 rtl/dmx_slot_loader.sv | 170 +++++++++++++++++
 tb/tb_dmx_slot_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// Shared constants and parser state encoding for the DMX slot loader.
package dmx_pkg;

    localparam int unsigned NUM_SLOTS   = 512;
    localparam int unsigned SLOT_ADDR_W = 9;
    localparam logic [7:0]  SYNC_BYTE   = 8'h7E;

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR_HI,
        S_ADDR_LO,
        S_COUNT,
        S_DATA,
        S_CSUM
    } state_e;

endpackage

// File: rtl/dmx_slot_ram.sv
// 512x8 slot RAM: one synchronous write port, one registered read port.
// Read and write of the same address in one cycle return the old value.
// No reset on the array or read register so it maps onto a single BRAM.
module dmx_slot_ram
    import dmx_pkg::*;
#(
    parameter int unsigned DEPTH = NUM_SLOTS,
    parameter int unsigned AW    = SLOT_ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Write port and read-before-write registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dmx_slot_loader.sv
// Parses framed slot-update commands from the UART byte stream into the slot
// RAM and serves the packetizer's slot lookups. Slot 0 always reads as 0x00.
// Optional trailing XOR checksum byte: define DMX_LOADER_CHECKSUM_EN.
module dmx_slot_loader
    import dmx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 12000
) (
    input  logic       CLK12,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic [9:0] rd_slot,
    output logic [7:0] rd_byte,
    output logic       cmd_ok,
    output logic       cmd_err,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [SLOT_ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]             remain_q, remain_d;   // 1..256 data bytes left
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   ok_q, ok_d;
    logic                   err_q, err_d;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic                   zero_q;               // force read data to 0x00
    logic                   ram_we;
    logic [7:0]             ram_rd_data;
`ifdef DMX_LOADER_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif

    dmx_slot_ram #(
        .DEPTH (NUM_SLOTS),
        .AW    (SLOT_ADDR_W)
    ) u_ram (
        .clk     (CLK12),
        .we      (ram_we),
        .wr_addr (addr_q),
        .wr_data (rx_byte),
        .rd_addr (rd_slot[SLOT_ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    // Next-state logic: command parser, inter-byte timeout and error counter.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        timer_d   = timer_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        ram_we    = 1'b0;
`ifdef DMX_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        // A received byte always restarts the idle timer, even on the last count.
        if (state_q == S_HUNT || rx_valid) begin
            timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
            timer_d = '0;
            state_d = S_HUNT;
            err_d   = 1'b1;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (rx_valid) begin
            unique case (state_q)
                S_HUNT: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    addr_d[8] = rx_byte[0];
                    state_d   = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    addr_d[7:0] = rx_byte;
                    state_d     = S_COUNT;
                end
                S_COUNT: begin
                    remain_d = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                    state_d  = S_DATA;
                end
                S_DATA: begin
                    // Slot 0 is the start code: drop the write, keep walking.
                    ram_we   = !reset && (addr_q != '0);
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 9'd1;
                    if (remain_q == 9'd1) begin
`ifdef DMX_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_HUNT;
                        ok_d    = 1'b1;
`endif
                    end
                end
`ifdef DMX_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    state_d = S_HUNT;
                    if (rx_byte == csum_q) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
                default: state_d = S_HUNT;
            endcase

`ifdef DMX_LOADER_CHECKSUM_EN
            if (state_q == S_HUNT) begin
                csum_d = '0;
            end else if (state_q != S_CSUM) begin
                csum_d = csum_q ^ rx_byte;
            end
`endif
        end

        if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State registers; reset abandons any command silently.
    always_ff @(posedge CLK12) begin
        if (reset) begin
            state_q   <= S_HUNT;
            addr_q    <= '0;
            remain_q  <= '0;
            timer_q   <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            zero_q    <= 1'b1;
`ifdef DMX_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            timer_q   <= timer_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            zero_q    <= (rd_slot[SLOT_ADDR_W-1:0] == '0) || (32'(rd_slot) >= NUM_SLOTS);
`ifdef DMX_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign rd_byte   = zero_q ? 8'h00 : ram_rd_data;
    assign cmd_ok    = ok_q;
    assign cmd_err   = err_q;
    assign busy      = (state_q != S_HUNT);
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_dmx_slot_loader.sv
// Self-checking bench for dmx_slot_loader against a slot-array reference model.
module tb_dmx_slot_loader;

    localparam int T = 12000;
`ifdef DMX_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic       CLK12 = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [9:0] rd_slot;
    logic [7:0] rd_byte;
    logic       cmd_ok;
    logic       cmd_err;
    logic       busy;
    logic [7:0] err_count;

    dmx_slot_loader #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK12     (CLK12),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rd_slot   (rd_slot),
        .rd_byte   (rd_byte),
        .cmd_ok    (cmd_ok),
        .cmd_err   (cmd_err),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 CLK12 = ~CLK12;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ok_cnt   = 0;
    int         err_cnt  = 0;
    int         both_cnt = 0;
    int         model_errs = 0;
    logic [7:0] model_mem [512];
    logic [7:0] payload [$];

    // Pulse monitor, sampled mid-cycle.
    always @(negedge CLK12) begin
        if (cmd_ok)  ok_cnt++;
        if (cmd_err) err_cnt++;
        if (cmd_ok && cmd_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK12);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    function automatic logic [7:0] exp_slot(input int s);
        if (s == 0 || s >= 512) return 8'h00;
        return model_mem[s];
    endfunction

    task automatic check_read(input int slot, input string tag);
        rd_slot = 10'(slot);
        tick();
        check(tag, rd_byte, exp_slot(slot));
    endtask

    // Send one full command with the current payload and check its outcome.
    task automatic send_cmd(input int addr, input bit bad, input bit probe_last, input string tag);
        logic [7:0] hi, lo, cnt, cs;
        int         ok0, err0, n;
        bit         exp_err;
        n  = payload.size();
        hi = 8'($urandom);
        hi[0] = addr[8];
        lo  = addr[7:0];
        cnt = 8'(n);
        cs  = hi ^ lo ^ cnt;
        foreach (payload[i]) cs ^= payload[i];
        ok0  = ok_cnt;
        err0 = err_cnt;
        send_byte(8'h7E); gap();
        send_byte(hi);    gap();
        send_byte(lo);    gap();
        send_byte(cnt);   gap();
        for (int i = 0; i < n; i++) begin
            if (probe_last && i == n - 1) begin
                check({tag, "_early_ok"}, ok_cnt - ok0, 0);
                check({tag, "_busy_mid"}, busy, 1);
            end
            send_byte(payload[i]);
            gap();
        end
        exp_err = bad && CSUM_ON;
        if (CSUM_ON) send_byte(bad ? ~cs : cs);
        for (int i = 0; i < n; i++) begin
            if ((addr + i) % 512 != 0) model_mem[(addr + i) % 512] = payload[i];
        end
        tick();
        tick();
        check({tag, "_ok"}, ok_cnt - ok0, exp_err ? 0 : 1);
        check({tag, "_err"}, err_cnt - err0, exp_err ? 1 : 0);
        check({tag, "_busy"}, busy, 0);
        if (exp_err && model_errs < 255) model_errs++;
        check({tag, "_errcnt"}, err_count, model_errs);
    endtask

    initial begin
        int ok0, err0, n;
        bit seen;
        logic [7:0] oldv;

        foreach (model_mem[i]) model_mem[i] = 8'h00;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        rd_slot  = 10'd0;
        tick();
        tick();
        // Reset must win over a simultaneous sync byte.
        rx_valid = 1'b1;
        rx_byte  = 8'h7E;
        tick();
        reset    = 1'b0;
        rx_valid = 1'b0;
        tick();
        check("rst_rd_byte", rd_byte, 8'h00);
        check("rst_cmd_ok", cmd_ok, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_busy", busy, 0);
        check("rst_err_count", err_count, 0);

        // COUNT=0 means 256 bytes; slots 1..256 get 0..255.
        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'(i));
        send_cmd(1, 1'b0, 1'b1, "count0");
        check_read(1, "count0_s1");
        check_read(256, "count0_s256");
        check_read(128, "count0_s128");

        // Fill the rest of the RAM so every slot is model-tracked.
        payload.delete();
        for (int i = 0; i < 255; i++) payload.push_back(8'($urandom));
        send_cmd(257, 1'b0, 1'b0, "fill");
        check_read(511, "fill_s511");

        // Basic write.
        payload.delete();
        payload.push_back(8'hFF); payload.push_back(8'h05); payload.push_back(8'h10);
        send_cmd(1, 1'b0, 1'b0, "basic");
        check_read(2, "basic_s2");
        check_read(0, "basic_s0");
        check_read(1, "basic_s1");
        check_read(3, "basic_s3");

        // Wrap from 511 to 0; slot 0 write dropped.
        payload.delete();
        payload.push_back(8'hAA); payload.push_back(8'hBB);
        send_cmd(511, 1'b0, 1'b0, "wrap");
        check_read(511, "wrap_s511");
        check_read(0, "wrap_s0");
        check_read(1, "wrap_s1");

        // Bad checksum: reported, data still written.
        if (CSUM_ON) begin
            payload.delete();
            payload.push_back(8'hFF); payload.push_back(8'h05); payload.push_back(8'h10);
            send_cmd(1, 1'b1, 1'b0, "badcs");
            check_read(1, "badcs_s1");
            check_read(2, "badcs_s2");
            check_read(3, "badcs_s3");
        end

        // Read-before-write on the same slot.
        oldv    = model_mem[3];
        rd_slot = 10'd3;
        ok0     = ok_cnt;
        send_byte(8'h7E);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(~oldv);
        check("rbw_old", rd_byte, oldv);
        model_mem[3] = ~oldv;
        if (CSUM_ON) send_byte(8'h00 ^ 8'h03 ^ 8'h01 ^ ~oldv);
        tick();
        check("rbw_new", rd_byte, model_mem[3]);
        tick();
        check("rbw_ok", ok_cnt - ok0, 1);

        // Inter-byte timeout.
        err0 = err_cnt;
        send_byte(8'h7E);
        send_byte(8'h00);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < T + 20) begin
            tick();
            n++;
            if (n == T - 5) check("to_busy_before", busy, 1);
            if (cmd_err) seen = 1'b1;
        end
        check("to_cycles_in_window", (n >= T - 1 && n <= T + 1) ? 1 : 0, 1);
        tick();
        check("to_busy_after", busy, 0);
        check("to_err_pulse", err_cnt - err0, 1);
        if (model_errs < 255) model_errs++;
        check("to_errcnt", err_count, model_errs);
        payload.delete();
        payload.push_back(8'h42);
        send_cmd(40, 1'b0, 1'b0, "after_to");

        // Reset mid-command: two data bytes written, third blocked by reset.
        ok0  = ok_cnt;
        err0 = err_cnt;
        send_byte(8'h7E);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        model_mem[5] = 8'h11;
        model_mem[6] = 8'h22;
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h33;
        tick();
        reset    = 1'b0;
        rx_valid = 1'b0;
        model_errs = 0;
        tick();
        check("rstmid_busy", busy, 0);
        check("rstmid_errcnt", err_count, 0);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'hCC);
        tick();
        check("rstmid_busy_nosync", busy, 0);
        check("rstmid_ok", ok_cnt - ok0, 0);
        check("rstmid_err", err_cnt - err0, 0);
        check_read(5, "rstmid_s5");
        check_read(6, "rstmid_s6");
        check_read(7, "rstmid_s7");

        // Randomized commands.
        for (int k = 0; k < 30; k++) begin
            payload.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) payload.push_back(8'($urandom));
            send_cmd(int'($urandom_range(0, 511)), 1'($urandom_range(0, 3) == 0), 1'b0, "rand");
        end

        // Randomized reads over the full 10-bit slot index range.
        for (int k = 0; k < 150; k++) begin
            check_read(int'($urandom_range(0, 1023)), "rand_rd");
        end
        check_read(512, "rd_512");
        check_read(1023, "rd_1023");

        check("ok_err_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
